// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE754 single-precision types and constants for the FP datapath
package fp_pkg;
  localparam int MANT_W = 23;
  localparam int EXP_W = 8;
  localparam int BIAS = 127;
  localparam int Q_W = 25;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;
  typedef enum logic [2:0] {IDLE, ARM, LOAD, PREP, DIV, NORM} fpdiv_state_t;
endpackage

// File: rtl/mant_div_seq.sv
// mant_div_seq: restoring bit-serial mantissa divider, one quotient bit per cycle after go
module mant_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic [24:0] q,
  output logic        qdone
);
  // remainder stays below twice the divisor, so 25 bits never overflow
  logic [24:0] rem, diff;
  logic [23:0] dvs;
  logic [4:0] cnt;
  logic run, ge;
  assign ge = rem >= {1'b0, dvs};
  assign diff = ge ? rem - {1'b0, dvs} : rem;
  assign qdone = run && cnt == 5'(Q_W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      dvs <= '0;
      q <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (go) begin
      rem <= {1'b0, dividend};
      dvs <= divisor;
      q <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      rem <= diff << 1;
      q <= {q[23:0], ge};
      cnt <= cnt + 5'd1;
      run <= !qdone;
    end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential truncating fp32 divider; FPDIV_SPECIAL_EN adds special-value handling and dz
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        dz
);
`ifdef FPDIV_SPECIAL_EN
  localparam int EW = 10;
`else
  localparam int EW = EXP_W;
`endif
  fpdiv_state_t state, nxt;
  fp32_t ar, br;
  logic sign, qdone, go, special;
  logic signed [EW-1:0] e, ee;
  logic [24:0] q;
  logic [31:0] nres;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? ARM : IDLE;
      ARM: nxt = start ? ARM : LOAD;
      LOAD: nxt = PREP;
      PREP: nxt = special ? NORM : DIV;
      DIV: nxt = qdone ? NORM : DIV;
      default: nxt = IDLE;
    endcase
  end
  assign done = state == IDLE;
  assign busy = !done;
  assign go = state == PREP && !special;
  mant_div_seq u_core (
    .clk(clk),
    .rst(rst),
    .go(go),
    .dividend({1'b1, ar.frac}),
    .divisor({1'b1, br.frac}),
    .q(q),
    .qdone(qdone)
  );
  assign ee = q[24] ? e : e - EW'(1);
`ifdef FPDIV_SPECIAL_EN
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_nan, spc;
  logic [31:0] spv, sval;
  logic s;
  assign s = ar.sign ^ br.sign;
  assign a_zero = ar.exp == '0;
  assign b_zero = br.exp == '0;
  assign a_inf = &ar.exp && ar.frac == '0;
  assign b_inf = &br.exp && br.frac == '0;
  assign a_nan = &ar.exp && |ar.frac;
  assign b_nan = &br.exp && |br.frac;
  assign is_nan = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
  assign special = is_nan || a_zero || b_zero || a_inf || b_inf;
  assign sval = is_nan ? QNAN : b_zero ? {s, 8'hFF, 23'd0} : (a_zero || b_inf) ? {s, 31'd0} : {s, 8'hFF, 23'd0};
  assign nres = spc ? spv : ee >= 10'sd255 ? {sign, 8'hFF, 23'd0} : ee <= 10'sd0 ? {sign, 31'd0} :
                {sign, ee[7:0], q[24] ? q[23:1] : q[22:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      spc <= 1'b0;
      spv <= '0;
      dz <= 1'b0;
    end else if (state == LOAD) dz <= 1'b0;
    else if (state == PREP) begin
      spc <= special;
      spv <= sval;
      dz <= b_zero && !a_zero && !a_nan;
    end
`else
  assign special = 1'b0;
  assign dz = 1'b0;
  assign nres = {sign, ee[7:0], q[24] ? q[23:1] : q[22:0]};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ar <= '0;
      br <= '0;
      sign <= 1'b0;
      e <= '0;
      result <= '0;
    end else begin
      state <= nxt;
      if (state == LOAD) begin
        ar <= a;
        br <= b;
      end
      if (state == PREP) begin
        sign <= ar.sign ^ br.sign;
        e <= EW'(ar.exp) - EW'(br.exp) + EW'(BIAS);
      end
      if (state == NORM) result <= nres;
    end
endmodule
